// File: rtl/e_muldiv_pkg.sv
// ============================================================================
// Module   : e_muldiv_pkg
// Brief    : Shared types and constants for the E-stage multiply/divide unit.
// Macro    : MULDIV_MADD_EN (enables the multiply-accumulate op codes)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package e_muldiv_pkg;

  // Operation codes presented on e_muldiv.op. The accumulate codes are always
  // enumerated so encodings stay fixed; without MULDIV_MADD_EN they act as MD_NONE.
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8,
    MD_MSUB  = 4'd9,
    MD_MSUBU = 4'd10
  } muldiv_op;

  localparam int C_MULT_LAT_DEFAULT = 5;
  localparam int C_DIV_LAT_DEFAULT  = 10;

  // Larger of two latencies; sizes the busy counter.
  function automatic int max_lat(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/e_muldiv_calc.sv
// ============================================================================
// Module   : muldiv_calc
// Brief    : Combinational 64-bit {HI,LO} result generator for mult/div ops.
//            Divide-by-zero returns the current {HI,LO}, so writing the
//            result back at completion leaves HI/LO unchanged.
// Macro    : MULDIV_MADD_EN (adds madd/maddu/msub/msubu)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_calc
  import e_muldiv_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res,
  output logic        is_long,
  output logic        is_div
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_b_zero;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_mag_safe;
  logic [31:0] w_b_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_sq;
  logic [31:0] w_sr;
  logic [31:0] w_uq;
  logic [31:0] w_ur;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign w_prod_u = {32'd0, a} * {32'd0, b};

  // Signed division on magnitudes; this also yields 0x80000000/-1 = 0x80000000, rem 0.
  assign w_b_zero     = (b == 32'd0);
  assign w_a_mag      = a[31] ? (32'd0 - a) : a;
  assign w_b_mag      = b[31] ? (32'd0 - b) : b;
  assign w_b_mag_safe = w_b_zero ? 32'd1 : w_b_mag;
  assign w_b_safe     = w_b_zero ? 32'd1 : b;
  assign w_q_mag      = w_a_mag / w_b_mag_safe;
  assign w_r_mag      = w_a_mag % w_b_mag_safe;
  assign w_sq         = (a[31] ^ b[31]) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_sr         = a[31] ? (32'd0 - w_r_mag) : w_r_mag;
  assign w_uq         = a / w_b_safe;
  assign w_ur         = a % w_b_safe;

  // Select result and operation class by op code.
  always_comb begin
    res     = {hi, lo};
    is_long = 1'b0;
    is_div  = 1'b0;
    case (op)
      MD_MULT:  begin is_long = 1'b1; res = w_prod_s; end
      MD_MULTU: begin is_long = 1'b1; res = w_prod_u; end
      MD_DIV: begin
        is_long = 1'b1;
        is_div  = 1'b1;
        if (!w_b_zero) res = {w_sr, w_sq};
      end
      MD_DIVU: begin
        is_long = 1'b1;
        is_div  = 1'b1;
        if (!w_b_zero) res = {w_ur, w_uq};
      end
`ifdef MULDIV_MADD_EN
      MD_MADD:  begin is_long = 1'b1; res = {hi, lo} + w_prod_s; end
      MD_MADDU: begin is_long = 1'b1; res = {hi, lo} + w_prod_u; end
      MD_MSUB:  begin is_long = 1'b1; res = {hi, lo} - w_prod_s; end
      MD_MSUBU: begin is_long = 1'b1; res = {hi, lo} - w_prod_u; end
`endif
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/e_muldiv.sv
// ============================================================================
// Module   : e_muldiv
// Brief    : Execute-stage multiply/divide unit. Owns HI/LO, runs mult/div
//            with fixed latency, raises busy while an operation is in flight.
// Macro    : MULDIV_MADD_EN (multiply-accumulate ops, see muldiv_calc)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module e_muldiv
  import e_muldiv_pkg::*;
#(
  parameter int MULT_LAT = C_MULT_LAT_DEFAULT,
  parameter int DIV_LAT  = C_DIV_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int C_CNT_W = $clog2(max_lat(MULT_LAT, DIV_LAT) + 1);

  logic [C_CNT_W-1:0] r_cnt;
  logic [63:0]        r_pend;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [63:0]        w_res;
  logic               w_is_long;
  logic               w_is_div;
  logic               w_idle;

  muldiv_calc u_calc (
    .op      (op),
    .a       (A),
    .b       (B),
    .hi      (r_hi),
    .lo      (r_lo),
    .res     (w_res),
    .is_long (w_is_long),
    .is_div  (w_is_div)
  );

  assign w_idle = (r_cnt == '0);
  assign busy   = !w_idle;
  assign HI     = r_hi;
  assign LO     = r_lo;

  // Busy countdown, pending-result capture and HI/LO update; starts while busy are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_pend <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else if (!w_idle) begin
      r_cnt <= r_cnt - C_CNT_W'(1);
      if (r_cnt == C_CNT_W'(1)) begin
        r_hi <= r_pend[63:32];
        r_lo <= r_pend[31:0];
      end
    end else if (start) begin
      if (w_is_long) begin
        r_cnt  <= w_is_div ? C_CNT_W'(DIV_LAT) : C_CNT_W'(MULT_LAT);
        r_pend <= w_res;
      end else if (op == MD_MTHI) begin
        r_hi <= A;
      end else if (op == MD_MTLO) begin
        r_lo <= A;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_e_muldiv.sv
// ============================================================================
// Module   : tb_e_muldiv
// Brief    : Self-checking bench for e_muldiv: directed table, busy-period
//            corner sequences and random ops against a behavioural model.
// Macro    : MULDIV_MADD_EN (model follows the same build option)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_e_muldiv;
  import e_muldiv_pkg::*;

  localparam int C_ML = 5;
  localparam int C_DL = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] mhi = 32'd0;
  logic [31:0] mlo = 32'd0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bit          chg;
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl[9];

  e_muldiv #(.MULT_LAT(C_ML), .DIV_LAT(C_DL)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Architectural model: latency and new {HI,LO} from the instruction semantics.
  function automatic void ref_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] hi, input logic [31:0] lo,
                                 output int lat, output logic [63:0] res);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, ps, pu;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ps  = sa * sb;
    pu  = ua * ub;
    lat = 0;
    res = {hi, lo};
    case (o)
      4'd1: begin lat = C_ML; res = ps; end
      4'd2: begin lat = C_ML; res = pu; end
      4'd3: begin
        lat = C_DL;
        if (b != 0) begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      4'd4: begin
        lat = C_DL;
        if (b != 0) res = {a % b, a / b};
      end
      4'd5: res = {a, lo};
      4'd6: res = {hi, a};
`ifdef MULDIV_MADD_EN
      4'd7:  begin lat = C_ML; res = {hi, lo} + ps; end
      4'd8:  begin lat = C_ML; res = {hi, lo} + pu; end
      4'd9:  begin lat = C_ML; res = {hi, lo} - ps; end
      4'd10: begin lat = C_ML; res = {hi, lo} - pu; end
`endif
      default: ;
    endcase
  endfunction

  // Issue one op, measure busy length, check HI/LO held while busy and final value.
  task automatic run_op(input string nm, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit chg, input int lat,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    bit early;
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    if (chg) begin A = 32'd0; B = 32'd0; end
    n = 0;
    early = 1'b0;
    while (busy === 1'b1 && n < 64) begin
      if ({HI, LO} !== {mhi, mlo}) early = 1'b1;
      n++;
      @(negedge clk);
    end
    chk({nm, " busy_cycles"}, 64'(n), 64'(lat));
    chk({nm, " hold"}, {63'd0, early}, 64'd0);
    chk({nm, " HI"}, {32'd0, HI}, {32'd0, ehi});
    chk({nm, " LO"}, {32'd0, LO}, {32'd0, elo});
    mhi = ehi;
    mlo = elo;
  endtask

  initial begin
    int          n;
    int          lat;
    logic [63:0] res;
    logic [3:0]  ro;
    logic [31:0] ra, rb;

    tbl[0] = '{4'd1, 32'hFFFFFFFE, 32'd3,        1'b0, C_ML, 32'hFFFFFFFF, 32'hFFFFFFFA};
    tbl[1] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, C_ML, 32'hFFFFFFFE, 32'h00000001};
    tbl[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,        1'b0, C_DL, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, C_DL, 32'h00000000, 32'h80000000};
    tbl[4] = '{4'd4, 32'd100,      32'd7,        1'b1, C_DL, 32'd2,        32'd14};
    tbl[5] = '{4'd1, 32'h80000000, 32'h80000000, 1'b0, C_ML, 32'h40000000, 32'h00000000};
    tbl[6] = '{4'd5, 32'h11,       32'd0,        1'b0, 0,    32'h11,       32'h00000000};
    tbl[7] = '{4'd6, 32'h22,       32'd0,        1'b0, 0,    32'h11,       32'h22};
    tbl[8] = '{4'd4, 32'd5,        32'd0,        1'b0, C_DL, 32'h11,       32'h22};

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset HI", {32'd0, HI}, 64'd0);
    chk("reset LO", {32'd0, LO}, 64'd0);

    // Directed table
    for (int i = 0; i < 9; i++)
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].chg,
             tbl[i].lat, tbl[i].hi, tbl[i].lo);

    // mthi and a second mult/div start during busy are both ignored
    @(negedge clk);
    start = 1'b1; op = MD_MULT; A = 32'd7; B = 32'd6;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (busy === 1'b1) n++;
      start = (i < 2);
      op    = (i == 0) ? MD_MTHI : MD_DIV;
      A     = (i == 0) ? 32'hABCD : 32'd100;
      B     = 32'd3;
    end
    start = 1'b0; op = MD_NONE;
    chk("busy_ignore cycles", 64'(n), 64'(C_ML));
    chk("busy_ignore HI", {32'd0, HI}, 64'd0);
    chk("busy_ignore LO", {32'd0, LO}, 64'd42);
    mhi = 32'd0; mlo = 32'd42;

    // mtlo after completion: immediate, no busy
    run_op("mtlo_after", MD_MTLO, 32'h1234, 32'd0, 1'b0, 0, 32'd0, 32'h1234);

    // Start on the last busy edge (cnt==1) is ignored
    @(negedge clk);
    start = 1'b1; op = MD_MULT; A = 32'd3; B = 32'd5;
    @(negedge clk);
    start = 1'b0; op = MD_NONE;
    repeat (C_ML - 1) @(negedge clk);
    chk("last_edge busy_before", {63'd0, busy}, 64'd1);
    start = 1'b1; op = MD_MTLO; A = 32'h5555;
    @(negedge clk);
    start = 1'b0; op = MD_NONE;
    chk("last_edge busy_after", {63'd0, busy}, 64'd0);
    chk("last_edge HI", {32'd0, HI}, 64'd0);
    chk("last_edge LO", {32'd0, LO}, 64'd15);

    // Reset in cycle 3 of a divide aborts it and clears HI/LO
    @(negedge clk);
    start = 1'b1; op = MD_DIV; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0; op = MD_NONE;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset busy", {63'd0, busy}, 64'd0);
    chk("midreset HI", {32'd0, HI}, 64'd0);
    chk("midreset LO", {32'd0, LO}, 64'd0);
    repeat (C_DL + 2) @(negedge clk);
    chk("midreset later busy", {63'd0, busy}, 64'd0);
    chk("midreset later HILO", {HI, LO}, 64'd0);
    mhi = 32'd0; mlo = 32'd0;

    // Random ops against the model
    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 10));
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'h80000000;
      if ($urandom_range(0, 5) == 0) rb = 32'hFFFFFFFF;
      ref_op(ro, ra, rb, mhi, mlo, lat, res);
      run_op($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, 1'($urandom_range(0, 1)),
             lat, res[63:32], res[31:0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
